// File: rtl/hydra_pkg.sv
// Shared types and sizes for the SRAM match scheduler.
// The optional lock aging feature is enabled with SRAM_SCHED_AGING_EN.
package hydra_pkg;

    localparam int PORT_NUM        = 16;
    localparam int SRAM_NUM        = 32;
    localparam int VISCOUS_TIMEOUT = 64;
    localparam int IDLE_W          = $clog2(VISCOUS_TIMEOUT + 1);

    typedef logic [4:0] sram_id_t;
    typedef logic [3:0] port_id_t;

    typedef enum logic [1:0] {
        MODE_STATIC = 2'd0,
        MODE_SEMI   = 2'd1,
        MODE_DYN    = 2'd2
    } match_mode_e;

    // SRAM probed by a port for a given scan offset; every mode is a permutation
    // of the ports onto distinct SRAMs, so probes never collide.
    function automatic sram_id_t probe_sram(input logic [1:0] mode,
                                            input port_id_t p,
                                            input sram_id_t off);
        sram_id_t s;
        case (mode)
            MODE_STATIC: s = {p, off[0]};
            MODE_SEMI:   s = {p[3], {1'b0, p[2:0]} + off[3:0]};
            default:     s = {1'b0, p} + off;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/rr_arbiter_16.sv
// Sixteen-request round-robin picker: grants the first request at or after ptr.
module rr_arbiter_16
    import hydra_pkg::*;
(
    input  logic [15:0] req,
    input  logic [3:0]  ptr,
    output logic [15:0] gnt,
    output logic [3:0]  winner
);

    port_id_t idx;
    logic     found;

    // Walk the requests starting from ptr and stop at the first one found.
    always_comb begin
        gnt    = '0;
        winner = ptr;
        found  = 1'b0;
        idx    = '0;
        for (int i = 0; i < PORT_NUM; i++) begin
            idx = ptr + 4'(i);
            if (!found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                winner   = idx;
            end
        end
    end

endmodule

// File: rtl/sram_match_scheduler.sv
// Central scheduler: drives each port's probed SRAM, reports accessibility,
// arbitrates claims and owns the SRAM lock table.
// Optional lock aging (idle locks auto-release) is enabled with SRAM_SCHED_AGING_EN.
module sram_match_scheduler
    import hydra_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  match_mode,
    input  logic [15:0] match_enable,
    input  logic [15:0] match_suc,
    input  logic [79:0] best_sram,
    input  logic [15:0] wr_release,
    output logic [79:0] matching_sram,
    output logic [15:0] accessible,
    output logic [15:0] viscous,
    output logic [15:0] grant,
    output logic [15:0] match_retry,
    output logic [79:0] locked_sram
);

    logic [1:0]          mode_q;
    sram_id_t            offset_q, offset_d;
    port_id_t            rr_ptr_q, rr_ptr_d;
    logic [79:0]         matching_sram_q, matching_sram_d;
    logic [79:0]         locked_sram_q, locked_sram_d;
    logic [15:0]         viscous_q, viscous_d;
    logic [15:0]         grant_q, grant_d;
    logic [15:0]         retry_q, retry_d;

    logic                mode_change;
    logic [15:0]         claim;
    logic [SRAM_NUM-1:0] lock_v;
    port_id_t            owner     [SRAM_NUM];
    logic [15:0]         claim_req [SRAM_NUM];
    logic [15:0]         arb_gnt   [SRAM_NUM];
    port_id_t            arb_win   [SRAM_NUM];
    logic [SRAM_NUM-1:0] contested;
    sram_id_t            claim_sram;
    sram_id_t            probe_s;

`ifdef SRAM_SCHED_AGING_EN
    logic [PORT_NUM-1:0][IDLE_W-1:0] idle_q, idle_d;
`else
    // Without aging, a lock lives until wr_release or a mode change.
`endif

    assign mode_change = (match_mode != mode_q);
    assign claim       = match_suc & match_enable & {16{~mode_change}};

    // Per-SRAM view of the lock table, derived from the per-port ownership.
    always_comb begin
        lock_v = '0;
        for (int s = 0; s < SRAM_NUM; s++) owner[s] = '0;
        for (int p = 0; p < PORT_NUM; p++) begin
            if (viscous_q[p]) begin
                lock_v[locked_sram_q[p*5 +: 5]] = 1'b1;
                owner[locked_sram_q[p*5 +: 5]]  = port_id_t'(p);
            end
        end
    end

    // Gather claims on unlocked SRAMs, one request vector per SRAM.
    always_comb begin
        for (int s = 0; s < SRAM_NUM; s++) claim_req[s] = '0;
        for (int p = 0; p < PORT_NUM; p++) begin
            if (claim[p] && !lock_v[best_sram[p*5 +: 5]])
                claim_req[best_sram[p*5 +: 5]][p] = 1'b1;
        end
        for (int s = 0; s < SRAM_NUM; s++)
            contested[s] = |(claim_req[s] & (claim_req[s] - 16'd1));
    end

    for (genvar s = 0; s < SRAM_NUM; s++) begin : g_arb
        rr_arbiter_16 u_arb (
            .req    (claim_req[s]),
            .ptr    (rr_ptr_q),
            .gnt    (arb_gnt[s]),
            .winner (arb_win[s])
        );
    end

    // Next state: probes, claim outcome, lock install/free and pointer moves.
    // When several SRAMs are contested in one cycle, the lowest-numbered one
    // decides where the round-robin pointer goes.
    always_comb begin
        offset_d      = offset_q + 5'd1;
        rr_ptr_d      = rr_ptr_q;
        viscous_d     = viscous_q;
        locked_sram_d = locked_sram_q;
        grant_d       = '0;
        retry_d       = '0;
        claim_sram    = '0;
`ifdef SRAM_SCHED_AGING_EN
        idle_d        = idle_q;
`endif
        for (int p = 0; p < PORT_NUM; p++)
            matching_sram_d[p*5 +: 5] = probe_sram(match_mode, port_id_t'(p), offset_q);

        if (mode_change) begin
            offset_d      = '0;
            rr_ptr_d      = '0;
            viscous_d     = '0;
            locked_sram_d = '0;
            retry_d       = match_suc & match_enable;
`ifdef SRAM_SCHED_AGING_EN
            idle_d        = '0;
`endif
        end else begin
            for (int s = SRAM_NUM - 1; s >= 0; s--) begin
                if (contested[s]) rr_ptr_d = arb_win[s] + 4'd1;
            end
            for (int p = 0; p < PORT_NUM; p++) begin
                claim_sram = best_sram[p*5 +: 5];
                if (claim[p]) begin
                    if (lock_v[claim_sram] && owner[claim_sram] != port_id_t'(p)) begin
                        retry_d[p] = 1'b1;
                    end else if (lock_v[claim_sram]) begin
                        grant_d[p] = 1'b1;
                    end else if (arb_gnt[claim_sram][p]) begin
                        grant_d[p]                = 1'b1;
                        viscous_d[p]              = 1'b1;
                        locked_sram_d[p*5 +: 5]   = claim_sram;
                    end else begin
                        retry_d[p] = 1'b1;
                    end
                end
                if (!grant_d[p] && wr_release[p]) begin
                    viscous_d[p]            = 1'b0;
                    locked_sram_d[p*5 +: 5] = '0;
                end
`ifdef SRAM_SCHED_AGING_EN
                if (match_suc[p] || grant_d[p] || !viscous_d[p]) begin
                    idle_d[p] = '0;
                end else if (idle_q[p] == IDLE_W'(VISCOUS_TIMEOUT - 1)) begin
                    idle_d[p]               = '0;
                    viscous_d[p]            = 1'b0;
                    locked_sram_d[p*5 +: 5] = '0;
                end else begin
                    idle_d[p] = idle_q[p] + IDLE_W'(1);
                end
`endif
            end
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mode_q          <= match_mode;
            offset_q        <= '0;
            rr_ptr_q        <= '0;
            matching_sram_q <= '0;
            locked_sram_q   <= '0;
            viscous_q       <= '0;
            grant_q         <= '0;
            retry_q         <= '0;
`ifdef SRAM_SCHED_AGING_EN
            idle_q          <= '0;
`endif
        end else begin
            mode_q          <= match_mode;
            offset_q        <= offset_d;
            rr_ptr_q        <= rr_ptr_d;
            matching_sram_q <= matching_sram_d;
            locked_sram_q   <= locked_sram_d;
            viscous_q       <= viscous_d;
            grant_q         <= grant_d;
            retry_q         <= retry_d;
`ifdef SRAM_SCHED_AGING_EN
            idle_q          <= idle_d;
`endif
        end
    end

    // A probed SRAM is usable if it is free or already held by the prober.
    always_comb begin
        accessible = '0;
        probe_s    = '0;
        for (int p = 0; p < PORT_NUM; p++) begin
            probe_s       = matching_sram_q[p*5 +: 5];
            accessible[p] = ~lock_v[probe_s] | (owner[probe_s] == port_id_t'(p));
        end
    end

    assign matching_sram = matching_sram_q;
    assign locked_sram   = locked_sram_q;
    assign viscous       = viscous_q;
    assign grant         = grant_q;
    assign match_retry   = retry_q;

endmodule

// File: tb/tb_sram_match_scheduler.sv
// Self-checking bench for sram_match_scheduler: a per-SRAM ownership model
// checked every cycle, plus directed scenarios with literal expectations.
module tb_sram_match_scheduler;

    logic        clk;
    logic        rst_n;
    logic [1:0]  match_mode;
    logic [15:0] match_enable;
    logic [15:0] match_suc;
    logic [79:0] best_sram;
    logic [15:0] wr_release;
    logic [79:0] matching_sram;
    logic [15:0] accessible;
    logic [15:0] viscous;
    logic [15:0] grant;
    logic [15:0] match_retry;
    logic [79:0] locked_sram;

    int total = 0;
    int bad   = 0;
    bit chk_en = 0;

    // Model state: owner of each SRAM (-1 free), scan offset, rr pointer.
    int         own [32];
    int         m_off;
    int         m_rr;
    logic [1:0] m_mode;
    logic [4:0] e_match [16];
    logic [15:0] e_grant, e_retry;
    bit         probes_live;

    sram_match_scheduler dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .match_mode    (match_mode),
        .match_enable  (match_enable),
        .match_suc     (match_suc),
        .best_sram     (best_sram),
        .wr_release    (wr_release),
        .matching_sram (matching_sram),
        .accessible    (accessible),
        .viscous       (viscous),
        .grant         (grant),
        .match_retry   (match_retry),
        .locked_sram   (locked_sram)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [79:0] act, input logic [79:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] suc, input logic [15:0] rel);
        match_suc  = suc;
        wr_release = rel;
        @(negedge clk);
        match_suc  = '0;
        wr_release = '0;
    endtask

    task automatic setBest(input int p, input logic [4:0] s);
        best_sram[p*5 +: 5] = s;
    endtask

    function automatic logic [4:0] probeOf(input int p);
        return matching_sram[p*5 +: 5];
    endfunction

    function automatic logic [4:0] expProbe(input logic [1:0] md, input int p, input int off);
        int v;
        if (md == 2'd0)      v = 2 * p + (off % 2);
        else if (md == 2'd1) v = (p / 8) * 16 + ((p % 8) + off) % 16;
        else                 v = (p + off) % 32;
        return v[4:0];
    endfunction

    // Model update at each rising edge, from the inputs the DUT also sees.
    always @(posedge clk) begin
        logic [15:0] g, r, clm;
        int nown [32];
        int win, n, nr, q, s;
        bit rr_set;
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) own[i] = -1;
            for (int i = 0; i < 16; i++) e_match[i] = '0;
            m_off = 0; m_rr = 0; m_mode = match_mode;
            e_grant = '0; e_retry = '0; probes_live = 0;
        end else begin
            for (int p = 0; p < 16; p++) e_match[p] = expProbe(match_mode, p, m_off);
            probes_live = 1;
            clm = match_suc & match_enable;
            g = '0; r = '0;
            if (match_mode != m_mode) begin
                r = clm;
                for (int i = 0; i < 32; i++) own[i] = -1;
                m_off = 0; m_rr = 0; m_mode = match_mode;
            end else begin
                rr_set = 0; nr = m_rr;
                for (int sr = 0; sr < 32; sr++) begin
                    n = 0; win = 0;
                    if (own[sr] == -1) begin
                        for (int k = 0; k < 16; k++) begin
                            q = (m_rr + k) % 16;
                            if (clm[q] && int'(best_sram[q*5 +: 5]) == sr) begin
                                if (n == 0) win = q; else r[q] = 1'b1;
                                n++;
                            end
                        end
                    end
                    if (n > 0) g[win] = 1'b1;
                    if (n > 1 && !rr_set) begin nr = (win + 1) % 16; rr_set = 1; end
                end
                for (int p = 0; p < 16; p++) begin
                    if (clm[p]) begin
                        s = int'(best_sram[p*5 +: 5]);
                        if (own[s] == p) g[p] = 1'b1;
                        else if (own[s] != -1) r[p] = 1'b1;
                    end
                end
                nown = own;
                for (int p = 0; p < 16; p++)
                    if (g[p] || wr_release[p])
                        for (int i = 0; i < 32; i++) if (nown[i] == p) nown[i] = -1;
                for (int p = 0; p < 16; p++)
                    if (g[p]) nown[int'(best_sram[p*5 +: 5])] = p;
                own = nown;
                m_rr = nr;
                m_off = (m_off + 1) % 32;
            end
            e_grant = g; e_retry = r;
        end
    end

    // Compare every output against the model on each falling edge.
    always @(negedge clk) begin
        logic [79:0] em, el;
        logic [15:0] ea, ev;
        bit seen [32];
        int s, nd;
        if (chk_en) begin
            em = '0; el = '0; ea = '0; ev = '0;
            for (int p = 0; p < 16; p++) em[p*5 +: 5] = e_match[p];
            for (int i = 0; i < 32; i++) begin
                if (own[i] >= 0) begin
                    ev[own[i]] = 1'b1;
                    el[own[i]*5 +: 5] = 5'(i);
                end
            end
            for (int p = 0; p < 16; p++) begin
                s = int'(e_match[p]);
                ea[p] = (own[s] == -1) || (own[s] == p);
            end
            checkOutput("matching_sram", matching_sram, em);
            checkOutput("accessible", 80'(accessible), 80'(ea));
            checkOutput("viscous", 80'(viscous), 80'(ev));
            checkOutput("locked_sram", locked_sram, el);
            checkOutput("grant", 80'(grant), 80'(e_grant));
            checkOutput("match_retry", 80'(match_retry), 80'(e_retry));
            if (probes_live) begin
                for (int i = 0; i < 32; i++) seen[i] = 0;
                nd = 0;
                for (int p = 0; p < 16; p++) begin
                    if (!seen[probeOf(p)]) nd++;
                    seen[probeOf(p)] = 1;
                end
                checkOutput("probe_distinct", 80'(nd), 80'(16));
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, want finish before 100000");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit found;
        rst_n        = 1'b0;
        match_mode   = 2'd2;
        match_enable = 16'hFFFF;
        match_suc    = '0;
        best_sram    = '0;
        wr_release   = '0;
        repeat (2) @(negedge clk);
        chk_en = 1;
        @(negedge clk);
        checkOutput("reset_accessible", 80'(accessible), 80'(16'hFFFF));
        checkOutput("reset_matching", matching_sram, 80'(0));
        checkOutput("reset_viscous", 80'(viscous), 80'(0));
        rst_n = 1'b1;

        // Full dynamic scan: port 3 walks 3,4,...,31,0,...
        for (int i = 0; i < 64; i++) begin
            applyStimulus('0, '0);
            checkOutput("p3_dyn_probe", 80'(probeOf(3)), 80'((3 + i) % 32));
        end

        // Contention on SRAM 1 from rr_ptr 0: port 4 wins, pointer moves to 5.
        setBest(4, 5'd1); setBest(10, 5'd1);
        applyStimulus(16'h0410, '0);
        checkOutput("arb1_grant", 80'(grant), 80'(16'h0010));
        checkOutput("arb1_retry", 80'(match_retry), 80'(16'h0400));
        // Ports 2 and 7 on SRAM 12 with rr_ptr 5: port 7 wins, pointer moves to 8.
        setBest(2, 5'd12); setBest(7, 5'd12);
        applyStimulus(16'h0084, '0);
        checkOutput("arb2_grant", 80'(grant), 80'(16'h0080));
        checkOutput("arb2_retry", 80'(match_retry), 80'(16'h0004));
        checkOutput("arb2_owner", 80'(locked_sram[35 +: 5]), 80'(12));
        // Ports 6 and 9 on SRAM 13 with rr_ptr 8: port 9 wins.
        setBest(6, 5'd13); setBest(9, 5'd13);
        applyStimulus(16'h0240, '0);
        checkOutput("arb3_grant", 80'(grant), 80'(16'h0200));
        checkOutput("arb3_retry", 80'(match_retry), 80'(16'h0040));

        // Port 4 moves to SRAM 9; port 6 probing 9 must see it locked.
        setBest(4, 5'd9);
        applyStimulus(16'h0010, '0);
        checkOutput("p4_move_grant", 80'(grant), 80'(16'h0010));
        checkOutput("p4_locked", 80'(locked_sram[20 +: 5]), 80'(9));
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (probeOf(6) == 5'd9) found = 1; else applyStimulus('0, '0);
        end
        if (found) checkOutput("acc6_locked", 80'(accessible[6]), 80'(0));
        else begin total++; bad++; $display("[TB] FAIL wait_probe9: got no probe, want port 6 on SRAM 9"); end
        applyStimulus('0, 16'h0010);
        checkOutput("p4_released", 80'(viscous[4]), 80'(0));
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (probeOf(6) == 5'd9) found = 1; else applyStimulus('0, '0);
        end
        if (found) checkOutput("acc6_free", 80'(accessible[6]), 80'(1));
        else begin total++; bad++; $display("[TB] FAIL wait_probe9b: got no probe, want port 6 on SRAM 9"); end

        // Port 1 takes SRAM 3, then moves to 20; SRAM 3 becomes free.
        setBest(1, 5'd3);
        applyStimulus(16'h0002, '0);
        checkOutput("p1_first", 80'(grant), 80'(16'h0002));
        setBest(1, 5'd20);
        applyStimulus(16'h0002, '0);
        checkOutput("p1_move", 80'(grant), 80'(16'h0002));
        checkOutput("p1_locked", 80'(locked_sram[5 +: 5]), 80'(20));
        setBest(0, 5'd3);
        applyStimulus(16'h0001, '0);
        checkOutput("p0_takes3", 80'(grant), 80'(16'h0001));
        applyStimulus(16'h0002, '0);
        checkOutput("p1_reclaim", 80'(grant), 80'(16'h0002));
        setBest(2, 5'd20);
        applyStimulus(16'h0004, '0);
        checkOutput("p2_blocked", 80'(match_retry), 80'(16'h0004));
        setBest(0, 5'd5);
        applyStimulus(16'h0001, 16'h0001);
        checkOutput("rel_claim_grant", 80'(grant), 80'(16'h0001));
        checkOutput("rel_claim_lock", 80'(locked_sram[0 +: 5]), 80'(5));
        match_enable[11] = 1'b0;
        setBest(11, 5'd30);
        applyStimulus(16'h0800, '0);
        checkOutput("disabled_retry", 80'(match_retry), 80'(0));
        match_enable[11] = 1'b1;
        setBest(8, 5'd25); setBest(9, 5'd26);
        applyStimulus(16'h0300, '0);
        checkOutput("distinct_grant", 80'(grant), 80'(16'h0300));

        // Mode change to semi-dynamic: claim retried, locks cleared.
        match_mode = 2'd1;
        setBest(3, 5'd7);
        applyStimulus(16'h0008, '0);
        checkOutput("modechg_retry", 80'(match_retry), 80'(16'h0008));
        checkOutput("modechg_viscous", 80'(viscous), 80'(0));
        for (int i = 0; i < 20; i++) begin
            applyStimulus('0, '0);
            if (i == 0) checkOutput("p9_semi_first", 80'(probeOf(9)), 80'(17));
            checkOutput("p9_semi_range", 80'(probeOf(9) >= 5'd16), 80'(1));
        end

        // Static mode: port 5 alternates 10,11 from offset 0.
        match_mode = 2'd0;
        applyStimulus('0, '0);
        applyStimulus('0, '0);
        checkOutput("p5_static0", 80'(probeOf(5)), 80'(10));
        applyStimulus('0, '0);
        checkOutput("p5_static1", 80'(probeOf(5)), 80'(11));
        applyStimulus('0, '0);
        checkOutput("p5_static2", 80'(probeOf(5)), 80'(10));

        // Reset arriving with a claim in flight: no grant, locks cleared.
        setBest(5, 5'd2);
        applyStimulus(16'h0020, '0);
        checkOutput("p5_pre_reset", 80'(grant), 80'(16'h0020));
        setBest(6, 5'd4);
        match_suc = 16'h0040;
        rst_n     = 1'b0;
        @(negedge clk);
        match_suc = '0;
        checkOutput("rst_claim_grant", 80'(grant), 80'(0));
        checkOutput("rst_claim_viscous", 80'(viscous), 80'(0));
        checkOutput("rst_claim_acc", 80'(accessible), 80'(16'hFFFF));
        rst_n = 1'b1;
        repeat (3) applyStimulus('0, '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
